// File: rtl/maze_mem_arbiter.sv
// Shares the single-port maze cell RAM among the renderer, carver and player.
// Grants and the RAM access are combinational in the same cycle; read data returns one cycle later.
// Display always wins; carver/player alternate round-robin; a clear sweep blocks every requester.
module maze_mem_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int CELL_W     = 2,
  parameter int START_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_req,
  output logic              clear_busy,
  output logic              clear_done,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_gnt,
  output logic              vid_rvalid,
  output logic [CELL_W-1:0] vid_rdata,
  input  logic              cv_req,
  input  logic              cv_we,
  input  logic [ADDR_W-1:0] cv_addr,
  input  logic [CELL_W-1:0] cv_wdata,
  output logic              cv_gnt,
  output logic              cv_rvalid,
  output logic [CELL_W-1:0] cv_rdata,
  input  logic              pl_req,
  input  logic [ADDR_W-1:0] pl_addr,
  output logic              pl_gnt,
  output logic              pl_rvalid,
  output logic [CELL_W-1:0] pl_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [CELL_W-1:0] mem_wdata,
  input  logic [CELL_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {ARB, CLEAR, SEED} state_t;

  localparam logic [ADDR_W:0]   CNT_ONE    = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] START_CELL = ADDR_W'(START_ADDR);
  localparam logic [CELL_W-1:0] CELL_PATH  = {CELL_W{1'b1}};

  state_t            state, state_nxt;
  logic [ADDR_W:0]   cnt, cnt_nxt;
  // rr_ptr = 0 prefers the carver, 1 prefers the player
  logic              rr_ptr, rr_nxt;
  logic [CELL_W-1:0] vid_hold, cv_hold, pl_hold;

  assign clear_busy = (state != ARB);

  // Read data is live from the RAM on the return cycle, otherwise the last returned value
  assign vid_rdata = vid_rvalid ? mem_rdata : vid_hold;
  assign cv_rdata  = cv_rvalid  ? mem_rdata : cv_hold;
  assign pl_rdata  = pl_rvalid  ? mem_rdata : pl_hold;

  // Next-state, arbitration and RAM command decode
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rr_nxt    = rr_ptr;
    vid_gnt   = 1'b0;
    cv_gnt    = 1'b0;
    pl_gnt    = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      ARB: begin
        if (vid_req) begin
          vid_gnt  = 1'b1;
          mem_en   = 1'b1;
          mem_addr = vid_addr;
        end else if (cv_req && (!pl_req || !rr_ptr)) begin
          cv_gnt    = 1'b1;
          mem_en    = 1'b1;
          mem_we    = cv_we;
          mem_addr  = cv_addr;
          mem_wdata = cv_we ? cv_wdata : '0;
          rr_nxt    = 1'b1;
        end else if (pl_req) begin
          pl_gnt   = 1'b1;
          mem_en   = 1'b1;
          mem_addr = pl_addr;
          rr_nxt   = 1'b0;
        end
        // The sweep starts next cycle; this cycle's grant still completes
        if (clear_req) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        mem_en   = 1'b1;
        mem_we   = 1'b1;
        mem_addr = cnt[ADDR_W-1:0];
        cnt_nxt  = cnt + CNT_ONE;
        // Counter carries into its top bit after the last cell is written
        if (cnt_nxt[ADDR_W]) state_nxt = SEED;
      end
      SEED: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = START_CELL;
        mem_wdata = CELL_PATH;
        cnt_nxt   = '0;
        state_nxt = ARB;
      end
      default: begin
        state_nxt = ARB;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State, sweep counter and round-robin pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ARB;
      cnt    <= '0;
      rr_ptr <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      rr_ptr <= rr_nxt;
    end
  end

  // Owner tags for the read returning next cycle, and the sweep-complete pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      vid_rvalid <= 1'b0;
      cv_rvalid  <= 1'b0;
      pl_rvalid  <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      vid_rvalid <= vid_gnt;
      cv_rvalid  <= cv_gnt && !cv_we;
      pl_rvalid  <= pl_gnt;
      clear_done <= (state == SEED);
    end
  end

  // Capture returned data so each rdata holds between returns
  always_ff @(posedge clk) begin
    if (reset) begin
      vid_hold <= '0;
      cv_hold  <= '0;
      pl_hold  <= '0;
    end else begin
      if (vid_rvalid) vid_hold <= mem_rdata;
      if (cv_rvalid)  cv_hold  <= mem_rdata;
      if (pl_rvalid)  pl_hold  <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_maze_mem_arbiter.sv
// Randomized and directed bench for maze_mem_arbiter with a cell RAM model.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
// A transaction-level model predicts grants, read returns and held read data.
module tb_maze_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear_req, clear_busy, clear_done;
  logic        vid_req, vid_gnt, vid_rvalid;
  logic [11:0] vid_addr;
  logic [1:0]  vid_rdata;
  logic        cv_req, cv_we, cv_gnt, cv_rvalid;
  logic [11:0] cv_addr;
  logic [1:0]  cv_wdata, cv_rdata;
  logic        pl_req, pl_gnt, pl_rvalid;
  logic [11:0] pl_addr;
  logic [1:0]  pl_rdata;
  logic        mem_en, mem_we;
  logic [11:0] mem_addr;
  logic [1:0]  mem_wdata, mem_rdata;

  int checks   = 0;
  int failures = 0;

  logic [1:0] ram [4096];
  logic [1:0] ref_mem [4096];

  always #5 clk = ~clk;

  maze_mem_arbiter #(.ADDR_W(12), .CELL_W(2), .START_ADDR(0)) dut (
    .clk(clk), .reset(reset),
    .clear_req(clear_req), .clear_busy(clear_busy), .clear_done(clear_done),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
    .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
    .cv_req(cv_req), .cv_we(cv_we), .cv_addr(cv_addr), .cv_wdata(cv_wdata),
    .cv_gnt(cv_gnt), .cv_rvalid(cv_rvalid), .cv_rdata(cv_rdata),
    .pl_req(pl_req), .pl_addr(pl_addr), .pl_gnt(pl_gnt),
    .pl_rvalid(pl_rvalid), .pl_rdata(pl_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Single-port cell RAM, one-cycle read latency
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clear_req = 0; vid_req = 0; vid_addr = 0;
    cv_req = 0; cv_we = 0; cv_addr = 0; cv_wdata = 0;
    pl_req = 0; pl_addr = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    step();
    step();
    reset = 0;
  endtask

  function automatic logic [31:0] out_vec();
    return {2'b00, vid_gnt, cv_gnt, pl_gnt, vid_rvalid, cv_rvalid, pl_rvalid,
            clear_busy, clear_done, mem_en, mem_we, mem_addr, mem_wdata,
            vid_rdata, cv_rdata, pl_rdata};
  endfunction

  // Random-phase model state
  logic       vp, cp, pp, cwe, pref_pl;
  logic [11:0] va, ca, pa;
  logic [1:0]  cwd, rv_data;
  int          rv_owner;
  logic [1:0]  last_v, last_c, last_p;

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 2'($urandom_range(0, 3));
    mem_rdata = 0;
    do_reset();

    // Reset state with idle requesters
    @(negedge clk);
    check_eq("reset_outputs", out_vec(), 32'd0);
    step();

    // Display priority, then carver/player alternation
    vid_req = 1; vid_addr = 1; cv_req = 1; cv_addr = 2; pl_req = 1; pl_addr = 3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("prio_vid", {29'd0, vid_gnt, cv_gnt, pl_gnt}, 32'b100);
      step();
    end
    vid_req = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("rr_alt", {29'd0, vid_gnt, cv_gnt, pl_gnt}, (i % 2 == 0) ? 32'b010 : 32'b001);
      step();
    end
    idle_inputs();
    step();

    // Full clear with the carver waiting on a read of cell 5
    clear_req = 1;
    @(negedge clk);
    check_eq("clr_req_busy", {31'd0, clear_busy}, 32'd0);
    step();
    clear_req = 0; cv_req = 1; cv_we = 0; cv_addr = 5;
    for (int k = 0; k < 4096; k++) begin
      @(negedge clk);
      check_eq("sweep", {14'd0, clear_busy, mem_en, mem_we, cv_gnt, mem_wdata, mem_addr},
               {14'd0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 12'(k)});
      step();
    end
    @(negedge clk);
    check_eq("seed", {13'd0, clear_busy, clear_done, mem_en, mem_we, cv_gnt, mem_wdata, mem_addr},
             {13'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 12'd0});
    step();
    @(negedge clk);
    check_eq("done_pulse", {29'd0, clear_busy, clear_done, cv_gnt}, 32'b011);
    check_eq("cv_rd5_cmd", {18'd0, mem_en, mem_we, mem_addr}, {18'd0, 1'b1, 1'b0, 12'd5});
    step();
    cv_req = 0;
    @(negedge clk);
    check_eq("cv_rd5_ret", {29'd0, clear_done, cv_rvalid, 1'b0}, 32'b010);
    check_eq("cv_rd5_data", {30'd0, cv_rdata}, 32'd0);
    step();

    // Read back every cell through the player port
    for (int a = 0; a < 4096; a++) ref_mem[a] = (a == 0) ? 2'b11 : 2'b00;
    pl_req = 1; pl_addr = 0;
    for (int a = 0; a <= 4096; a++) begin
      @(negedge clk);
      if (a < 4096) check_eq("rb_gnt", {31'd0, pl_gnt}, 32'd1);
      if (a > 0) check_eq("rb_data", {29'd0, pl_rvalid, pl_rdata}, {29'd0, 1'b1, ref_mem[a-1]});
      step();
      pl_addr = 12'(a + 1);
      if (a == 4095) pl_req = 0;
    end

    // Carver write then player read of the same cell
    cv_req = 1; cv_we = 1; cv_addr = 130; cv_wdata = 2'b10;
    @(negedge clk);
    check_eq("wr130_cmd", {16'd0, cv_gnt, mem_we, mem_wdata, mem_addr}, {16'd0, 1'b1, 1'b1, 2'b10, 12'd130});
    step();
    cv_req = 0; cv_we = 0; pl_req = 1; pl_addr = 130;
    @(negedge clk);
    check_eq("wr130_norv", {30'd0, cv_rvalid, pl_gnt}, 32'b01);
    step();
    pl_req = 0;
    @(negedge clk);
    check_eq("rd130", {28'd0, cv_rvalid, pl_rvalid, pl_rdata}, {28'd0, 1'b0, 1'b1, 2'b10});
    step();

    // Reset in the middle of a sweep
    clear_req = 1;
    step();
    clear_req = 0;
    for (int k = 0; k < 2000; k++) step();
    reset = 1;
    step();
    reset = 0;
    @(negedge clk);
    check_eq("midrst_busy", {30'd0, clear_busy, mem_we}, 32'd0);
    for (int k = 0; k < 10; k++) begin
      step();
      @(negedge clk);
      check_eq("midrst_nodone", {30'd0, clear_done, clear_busy}, 32'd0);
    end
    step();

    // Fresh clear after the aborted one: count the writes
    begin
      int writes;
      bit done_seen;
      writes = 0;
      done_seen = 0;
      clear_req = 1;
      step();
      clear_req = 0;
      for (int k = 0; k < 5000 && !done_seen; k++) begin
        @(negedge clk);
        if (mem_en && mem_we) writes++;
        if (clear_done) done_seen = 1;
        step();
      end
      check_eq("fresh_done", {31'd0, done_seen}, 32'd1);
      check_eq("fresh_writes", 32'(writes), 32'd4097);
    end

    // Randomized traffic against the transaction model
    do_reset();
    for (int a = 0; a < 4096; a++) ref_mem[a] = (a == 0) ? 2'b11 : 2'b00;
    vp = 0; cp = 0; pp = 0; pref_pl = 0; rv_owner = 0; rv_data = 0;
    last_v = 0; last_c = 0; last_p = 0;
    va = 0; ca = 0; pa = 0; cwe = 0; cwd = 0;
    for (int n = 0; n < 3000; n++) begin
      logic [2:0] eg;
      logic [2:0] erv;
      if (!vp && $urandom_range(0, 3) == 0) begin vp = 1; va = 12'($urandom_range(0, 63)); end
      if (!cp && $urandom_range(0, 1) == 1) begin
        cp = 1; ca = 12'($urandom_range(0, 63));
        cwe = 1'($urandom_range(0, 1)); cwd = 2'($urandom_range(0, 3));
      end
      if (!pp && $urandom_range(0, 1) == 1) begin pp = 1; pa = 12'($urandom_range(0, 63)); end
      vid_req = vp; vid_addr = va;
      cv_req = cp; cv_addr = ca; cv_we = cwe; cv_wdata = cwd;
      pl_req = pp; pl_addr = pa;
      @(negedge clk);
      if (vp)                  eg = 3'b100;
      else if (cp && pp)       eg = pref_pl ? 3'b001 : 3'b010;
      else if (cp)             eg = 3'b010;
      else if (pp)             eg = 3'b001;
      else                     eg = 3'b000;
      erv = (rv_owner == 1) ? 3'b100 : (rv_owner == 2) ? 3'b010 : (rv_owner == 3) ? 3'b001 : 3'b000;
      if (rv_owner == 1) last_v = rv_data;
      if (rv_owner == 2) last_c = rv_data;
      if (rv_owner == 3) last_p = rv_data;
      check_eq("rnd_gnt", {29'd0, vid_gnt, cv_gnt, pl_gnt}, {29'd0, eg});
      check_eq("rnd_rvalid", {29'd0, vid_rvalid, cv_rvalid, pl_rvalid}, {29'd0, erv});
      check_eq("rnd_rdata", {26'd0, vid_rdata, cv_rdata, pl_rdata}, {26'd0, last_v, last_c, last_p});
      rv_owner = 0;
      case (eg)
        3'b100: begin
          check_eq("rnd_mem", {18'd0, mem_en, mem_we, mem_addr}, {18'd0, 1'b1, 1'b0, va});
          rv_owner = 1; rv_data = ref_mem[va]; vp = 0;
        end
        3'b010: begin
          check_eq("rnd_mem", {16'd0, mem_en, mem_we, mem_wdata, mem_addr},
                   {16'd0, 1'b1, cwe, cwe ? cwd : 2'b00, ca});
          if (cwe) ref_mem[ca] = cwd;
          else begin rv_owner = 2; rv_data = ref_mem[ca]; end
          pref_pl = 1; cp = 0;
        end
        3'b001: begin
          check_eq("rnd_mem", {18'd0, mem_en, mem_we, mem_addr}, {18'd0, 1'b1, 1'b0, pa});
          rv_owner = 3; rv_data = ref_mem[pa]; pref_pl = 0; pp = 0;
        end
        default: check_eq("rnd_mem_idle", {31'd0, mem_en}, 32'd0);
      endcase
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
